// File: rtl/issue_scheduler_pkg.sv
// Shared types for the issue scheduler: decoded op, tags, queue entry.
// ISSUE_WAKEUP_BYPASS_EN (see issue_scheduler.sv) does not change these types.
package issue_scheduler_pkg;

  localparam int IQ_DEPTH_DEFAULT = 8;
  localparam int TAG_W = 7;
  localparam int AGE_W = 5;

  typedef logic [TAG_W-1:0] p_ref;
  typedef logic [AGE_W-1:0] age_t;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [31:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } decode_struct;

  typedef struct packed {
    logic         valid;
    decode_struct op;
    p_ref         psrc0;
    p_ref         psrc1;
    p_ref         pdst;
    logic         rdy0;
    logic         rdy1;
    age_t         age;
  } iq_entry_t;

  function automatic logic tag_hit(
    input logic v,
    input p_ref a,
    input p_ref b
  );
    return v && (a == b);
  endfunction

endpackage

// File: rtl/iq_oldest_select.sv
// Oldest-candidate picker: one-hot grant to the candidate with the
// smallest age rank. Ranks of valid entries are unique.
module iq_oldest_select
  import issue_scheduler_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]            cand,
  input  logic [N-1:0][AGE_W-1:0] age,
  output logic [N-1:0]            grant,
  output logic                    any
);

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = cand[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && cand[j] && (age[j] < age[i]))
          grant[i] = 1'b0;
      end
    end
  end

  assign any = |cand;

endmodule

// File: rtl/issue_scheduler.sv
// Single-issue out-of-order issue queue with tag wakeup and oldest-first select.
// Define ISSUE_WAKEUP_BYPASS_EN to let a same-cycle wakeup make an entry issuable.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             dispatch_valid,
  output logic             dispatch_ready,
  input  decode_struct     dispatch_op,
  input  p_ref             dispatch_psrc0,
  input  p_ref             dispatch_psrc1,
  input  p_ref             dispatch_pdst,
  input  logic             dispatch_rdy0,
  input  logic             dispatch_rdy1,
  input  logic             wakeup_valid,
  input  p_ref             wakeup_tag,
  output logic             issue_valid,
  input  logic             issue_ready,
  output decode_struct     issue_op,
  output p_ref             issue_psrc0,
  output p_ref             issue_psrc1,
  output p_ref             issue_pdst,
  output logic [CNT_W-1:0] count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  iq_entry_t q [DEPTH];
  logic [CNT_W-1:0] cnt;

  logic [DEPTH-1:0] wk0, wk1, cand, grant;
  logic [DEPTH-1:0][AGE_W-1:0] ages;
  logic any;

  decode_struct sel_op;
  p_ref sel_s0, sel_s1, sel_pd;
  age_t sel_age;

  logic acc, fire;
  logic [IDX_W-1:0] free_idx;
  iq_entry_t ent_new;
  age_t new_age;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wk0[i]  = tag_hit(wakeup_valid, wakeup_tag, q[i].psrc0);
      wk1[i]  = tag_hit(wakeup_valid, wakeup_tag, q[i].psrc1);
      ages[i] = q[i].age;
`ifdef ISSUE_WAKEUP_BYPASS_EN
      cand[i] = q[i].valid
              && (q[i].rdy0 || wk0[i])
              && (q[i].rdy1 || wk1[i]);
`else
      cand[i] = q[i].valid && q[i].rdy0 && q[i].rdy1;
`endif
    end
  end

  iq_oldest_select #(.N(DEPTH)) u_sel (
    .cand  (cand),
    .age   (ages),
    .grant (grant),
    .any   (any)
  );

  // grant is one-hot, so a priority mux is equivalent to an AND-OR mux
  always_comb begin
    sel_op  = '0;
    sel_s0  = '0;
    sel_s1  = '0;
    sel_pd  = '0;
    sel_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel_op  = q[i].op;
        sel_s0  = q[i].psrc0;
        sel_s1  = q[i].psrc1;
        sel_pd  = q[i].pdst;
        sel_age = q[i].age;
      end
    end
  end

  assign issue_valid    = any && !flush;
  assign issue_op       = sel_op;
  assign issue_psrc0    = sel_s0;
  assign issue_psrc1    = sel_s1;
  assign issue_pdst     = sel_pd;
  assign dispatch_ready = (cnt < FULL) && !flush;
  assign count          = cnt;

  assign acc  = dispatch_valid && dispatch_ready;
  assign fire = issue_valid && issue_ready;

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!q[i].valid)
        free_idx = IDX_W'(i);
    end
  end

  // ranks stay dense 0..count-1, so the newcomer lands just past the survivors
  assign new_age = age_t'(cnt) - age_t'(fire);

  always_comb begin
    ent_new       = '0;
    ent_new.valid = 1'b1;
    ent_new.op    = dispatch_op;
    ent_new.psrc0 = dispatch_psrc0;
    ent_new.psrc1 = dispatch_psrc1;
    ent_new.pdst  = dispatch_pdst;
    ent_new.rdy0  = dispatch_rdy0
                  || tag_hit(wakeup_valid, wakeup_tag, dispatch_psrc0);
    ent_new.rdy1  = dispatch_rdy1 || dispatch_op.alu_src
                  || tag_hit(wakeup_valid, wakeup_tag, dispatch_psrc1);
    ent_new.age   = new_age;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        q[i] <= '0;
    end else if (flush) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        q[i].valid <= 1'b0;
    end else begin
      cnt <= cnt + CNT_W'(acc) - CNT_W'(fire);
      for (int i = 0; i < DEPTH; i++) begin
        if (fire && grant[i]) begin
          q[i].valid <= 1'b0;
        end else if (acc && free_idx == IDX_W'(i)) begin
          q[i] <= ent_new;
        end else if (q[i].valid) begin
          if (wk0[i])
            q[i].rdy0 <= 1'b1;
          if (wk1[i])
            q[i].rdy1 <= 1'b1;
          if (fire && q[i].age > sel_age)
            q[i].age <= q[i].age - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: directed scenarios plus random
// traffic against an in-order list model (oldest = front of the queue).
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush;
  logic dispatch_valid, dispatch_ready;
  decode_struct dispatch_op;
  p_ref dispatch_psrc0, dispatch_psrc1, dispatch_pdst;
  logic dispatch_rdy0, dispatch_rdy1;
  logic wakeup_valid;
  p_ref wakeup_tag;
  logic issue_valid, issue_ready;
  decode_struct issue_op;
  p_ref issue_psrc0, issue_psrc1, issue_pdst;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_scheduler #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_op(dispatch_op), .dispatch_psrc0(dispatch_psrc0),
    .dispatch_psrc1(dispatch_psrc1), .dispatch_pdst(dispatch_pdst),
    .dispatch_rdy0(dispatch_rdy0), .dispatch_rdy1(dispatch_rdy1),
    .wakeup_valid(wakeup_valid), .wakeup_tag(wakeup_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_psrc0(issue_psrc0),
    .issue_psrc1(issue_psrc1), .issue_pdst(issue_pdst),
    .count(count)
  );

  typedef struct {
    decode_struct op;
    p_ref s0, s1, d;
    bit r0, r1;
  } m_t;

  m_t mq[$];

  function automatic decode_struct rand_op(bit alu_src);
    decode_struct o;
    o = decode_struct'({$urandom, $urandom});
    o.alu_src = alu_src;
    return o;
  endfunction

  function automatic int m_sel();
    for (int i = 0; i < mq.size(); i++) begin
      bit a, b;
      a = mq[i].r0;
      b = mq[i].r1;
`ifdef ISSUE_WAKEUP_BYPASS_EN
      if (wakeup_valid && wakeup_tag == mq[i].s0) a = 1;
      if (wakeup_valid && wakeup_tag == mq[i].s1) b = 1;
`endif
      if (a && b) return i;
    end
    return -1;
  endfunction

  task automatic idle();
    flush = 0;
    dispatch_valid = 0;
    dispatch_op = '0;
    dispatch_psrc0 = '0;
    dispatch_psrc1 = '0;
    dispatch_pdst = '0;
    dispatch_rdy0 = 0;
    dispatch_rdy1 = 0;
    wakeup_valid = 0;
    wakeup_tag = '0;
    issue_ready = 0;
  endtask

  task automatic offer(input decode_struct op, input p_ref s0, input p_ref s1,
                       input p_ref d, input bit r0, input bit r1);
    dispatch_valid = 1;
    dispatch_op = op;
    dispatch_psrc0 = s0;
    dispatch_psrc1 = s1;
    dispatch_pdst = d;
    dispatch_rdy0 = r0;
    dispatch_rdy1 = r1;
  endtask

  // Advance one clock edge, applying the same edge to the model.
  task automatic tick();
    int sel;
    bit fire, acc;
    m_t n;
    sel = m_sel();
    fire = !flush && sel >= 0 && issue_ready;
    acc = !flush && dispatch_valid && mq.size() < DEPTH;
    n.op = dispatch_op;
    n.s0 = dispatch_psrc0;
    n.s1 = dispatch_psrc1;
    n.d = dispatch_pdst;
    n.r0 = dispatch_rdy0 || (wakeup_valid && wakeup_tag == dispatch_psrc0);
    n.r1 = dispatch_rdy1 || dispatch_op.alu_src
        || (wakeup_valid && wakeup_tag == dispatch_psrc1);
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      if (wakeup_valid)
        foreach (mq[i]) begin
          if (mq[i].s0 == wakeup_tag) mq[i].r0 = 1;
          if (mq[i].s1 == wakeup_tag) mq[i].r1 = 1;
        end
      if (fire) mq.delete(sel);
      if (acc) mq.push_back(n);
    end
    @(negedge clk);
    idle();
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (count !== 0 || issue_valid !== 0 || dispatch_ready !== 1
        || issue_pdst !== 0 || issue_op !== '0) begin
      errors++;
      $display("FAIL reset_state cnt=%0d iv=%0b dr=%0b pd=%0d", count,
               issue_valid, dispatch_ready, issue_pdst);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      offer(rand_op(0), 7'(i), 7'(i), 7'(40+i), 0, 0);
      tick();
    end
    offer(rand_op(0), 1, 2, 50, 1, 1);
    #2 rst_n = 0;
    #1;
    checks++;
    if (count !== 0 || issue_valid !== 0 || dispatch_ready !== 1) begin
      errors++;
      $display("FAIL reset_async cnt=%0d iv=%0b dr=%0b (want 0 0 1)",
               count, issue_valid, dispatch_ready);
    end
    mq.delete();
    idle();
    @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  task automatic test_oldest_ready();
    offer(rand_op(0), 5, 3, 1, 0, 1);
    tick();
    offer(rand_op(0), 6, 7, 2, 1, 1);
    checks++;
    if (issue_valid !== 0) begin
      errors++;
      $display("FAIL ab_none iv=%0b want 0", issue_valid);
    end
    tick();
    issue_ready = 1;
    #1;
    checks++;
    if (issue_valid !== 1 || issue_pdst !== 2) begin
      errors++;
      $display("FAIL ab_b_first iv=%0b pd=%0d want 1 2", issue_valid, issue_pdst);
    end
    tick();
    issue_ready = 1;
    wakeup_valid = 1;
    wakeup_tag = 5;
    #1;
    checks++;
`ifdef ISSUE_WAKEUP_BYPASS_EN
    if (issue_valid !== 1 || issue_pdst !== 1) begin
`else
    if (issue_valid !== 0) begin
`endif
      errors++;
      $display("FAIL ab_wake_cycle iv=%0b pd=%0d", issue_valid, issue_pdst);
    end
    tick();
`ifndef ISSUE_WAKEUP_BYPASS_EN
    issue_ready = 1;
    #1;
    checks++;
    if (issue_valid !== 1 || issue_pdst !== 1) begin
      errors++;
      $display("FAIL ab_a_after iv=%0b pd=%0d want 1 1", issue_valid, issue_pdst);
    end
    tick();
`endif
    checks++;
    if (count !== 0) begin
      errors++;
      $display("FAIL ab_drain cnt=%0d want 0", count);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      offer(rand_op(0), 1, 1, 7'(60+i), 1, 1);
      tick();
    end
    checks++;
    if (dispatch_ready !== 0 || count !== 8) begin
      errors++;
      $display("FAIL full dr=%0b cnt=%0d want 0 8", dispatch_ready, count);
    end
    offer(rand_op(0), 1, 1, 99, 1, 1);
    issue_ready = 1;
    #1;
    checks++;
    if (issue_valid !== 1 || issue_pdst !== 60) begin
      errors++;
      $display("FAIL full_issue iv=%0b pd=%0d want 1 60", issue_valid, issue_pdst);
    end
    tick();
    checks++;
    if (count !== 7 || dispatch_ready !== 1) begin
      errors++;
      $display("FAIL full_no_same_cycle cnt=%0d dr=%0b want 7 1", count, dispatch_ready);
    end
    offer(rand_op(0), 1, 1, 99, 1, 1);
    tick();
    checks++;
    if (count !== 8) begin
      errors++;
      $display("FAIL full_ninth cnt=%0d want 8", count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      issue_ready = 1;
      #1;
      checks++;
      if (issue_valid !== 1 || issue_pdst !== mq[0].d) begin
        errors++;
        $display("FAIL full_drain pd=%0d want %0d", issue_pdst, mq[0].d);
      end
      tick();
    end
    checks++;
    if (count !== 0) begin
      errors++;
      $display("FAIL full_empty cnt=%0d want 0", count);
    end
  endtask

  task automatic test_alusrc();
    offer(rand_op(1), 4, 9, 33, 1, 0);
    tick();
    issue_ready = 1;
    #1;
    checks++;
    if (issue_valid !== 1 || issue_pdst !== 33 || issue_psrc1 !== 9) begin
      errors++;
      $display("FAIL alusrc iv=%0b pd=%0d want 1 33", issue_valid, issue_pdst);
    end
    tick();
  endtask

  task automatic test_dispatch_wakeup();
    offer(rand_op(0), 12, 3, 44, 0, 1);
    wakeup_valid = 1;
    wakeup_tag = 12;
    tick();
    issue_ready = 1;
    #1;
    checks++;
    if (issue_valid !== 1 || issue_pdst !== 44) begin
      errors++;
      $display("FAIL disp_wake iv=%0b pd=%0d want 1 44", issue_valid, issue_pdst);
    end
    tick();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      offer(rand_op(0), 2, 2, 7'(70+i), 1, 1);
      tick();
    end
    flush = 1;
    issue_ready = 1;
    offer(rand_op(0), 2, 2, 80, 1, 1);
    #1;
    checks++;
    if (issue_valid !== 0 || dispatch_ready !== 0 || count !== 5) begin
      errors++;
      $display("FAIL flush_cycle iv=%0b dr=%0b cnt=%0d want 0 0 5",
               issue_valid, dispatch_ready, count);
    end
    tick();
    checks++;
    if (count !== 0 || issue_valid !== 0) begin
      errors++;
      $display("FAIL flush_after cnt=%0d iv=%0b want 0 0", count, issue_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      int sel;
      bit exp_iv;
      flush = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 2) != 0)
        offer(rand_op(1'($urandom_range(0, 3) == 0)), 7'($urandom_range(0, 15)),
              7'($urandom_range(0, 15)), 7'($urandom_range(0, 127)),
              1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
      wakeup_valid = 1'($urandom_range(0, 1));
      wakeup_tag = 7'($urandom_range(0, 15));
      issue_ready = 1'($urandom_range(0, 2) != 0);
      #1;
      sel = m_sel();
      exp_iv = sel >= 0 && !flush;
      checks++;
      if (count !== CNT_W'(mq.size())
          || dispatch_ready !== (mq.size() < DEPTH && !flush)
          || issue_valid !== exp_iv) begin
        errors++;
        $display("FAIL rand_ctl c=%0d cnt=%0d/%0d dr=%0b iv=%0b/%0b", c,
                 count, mq.size(), dispatch_ready, issue_valid, exp_iv);
      end
      if (exp_iv) begin
        checks++;
        if (issue_pdst !== mq[sel].d || issue_op !== mq[sel].op
            || issue_psrc0 !== mq[sel].s0 || issue_psrc1 !== mq[sel].s1) begin
          errors++;
          $display("FAIL rand_sel c=%0d pd=%0d want %0d", c, issue_pdst, mq[sel].d);
        end
      end
      tick();
    end
  endtask

  initial begin
    idle();
    #1;
    test_reset();
    test_oldest_ready();
    test_full();
    test_alusrc();
    test_dispatch_wakeup();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
